// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Front-end fetch stage. Owns the program counter, drives the instruction
//   memory address combinationally from it, and captures {pc, instr} pairs
//   into a small FIFO that feeds decode through a valid/ready handshake.
//   Redirects reload the PC and flush the FIFO. Fetching halts once the PC
//   runs past the end of instruction memory.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   DEPTH      fetch buffer entries (power of two, >= 2)
//   IMEM_SIZE  instruction memory size in bytes
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   imem_addr        byte address to instruction memory (== pc)
//   imem_instr       instruction returned for imem_addr, same cycle
//   redirect_valid   load redirect_pc (word aligned) and flush the buffer
//   redirect_pc      redirect target
//   out_valid        buffer head valid
//   out_ready        decode accepts the head
//   out_pc           PC of the head entry
//   out_instr        instruction of the head entry
//   fetch_halted     pc is past the end of memory
//   stall_cycles     back-pressure cycle counter
//
// Build option
//   FETCH_PERF_CNT_EN  when defined, stall_cycles counts cycles where a fetch
//                      was possible but the buffer was full; otherwise it is
//                      tied to zero.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          DEPTH     = 2,
  parameter logic [63:0] IMEM_SIZE = 64'd4095
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_halted,
  output logic [31:0] stall_cycles
);

  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  fetch_entry_t  entries [DEPTH];
  logic [63:0]   pc;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [64:0]   pc_last_byte;
  logic          fetch_ok, pop, push, full;

  // Extra top bit so pc+3 overflow reads as out of range.
  assign pc_last_byte = {1'b0, pc} + 65'd3;
  assign fetch_halted = !(pc_last_byte < {1'b0, IMEM_SIZE});
  assign fetch_ok     = !fetch_halted;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign full      = (count == FULL);
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a push when the head leaves the same cycle.
  assign push      = fetch_ok && !redirect_valid && (!full || pop);

  assign out_pc    = entries[head].pc;
  assign out_instr = entries[head].instr;

  // Redirect target low bits are dropped; they are only read via this tap.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (redirect_valid) begin
      // Any pop this cycle is discarded along with the rest of the buffer.
      pc    <= {redirect_pc[63:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{pc: pc, instr: imem_instr};
        tail          <= tail + 1'b1;
        pc            <= pc + 64'd4;
      end
      if (pop) head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (fetch_ok && !redirect_valid && !push && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Instance dut uses default parameters;
// instance dut_s uses IMEM_SIZE=16 to exercise the end-of-memory halt.
module tb_instr_fetch_unit;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_halted;
  logic [31:0] stall_cycles;

  logic [63:0] imem_addr_s;
  logic [31:0] imem_instr_s;
  logic        redirect_valid_s;
  logic [63:0] redirect_pc_s;
  logic        out_valid_s;
  logic        out_ready_s;
  logic [63:0] out_pc_s;
  logic [31:0] out_instr_s;
  logic        fetch_halted_s;
  logic [31:0] stall_cycles_s;

  int n_checks = 0;
  int n_pass   = 0;

  // Instruction memory contents: two known words, then an address-tagged pattern.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   mem_word = 32'h0050_0093;
      64'h4:   mem_word = 32'h0010_0113;
      default: mem_word = 32'hC000_0000 + a[31:0];
    endcase
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign imem_instr_s = mem_word(imem_addr_s);

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_halted(fetch_halted), .stall_cycles(stall_cycles)
  );

  instr_fetch_unit #(.IMEM_SIZE(64'd16)) dut_s (
    .clk(clk), .reset(reset), .imem_addr(imem_addr_s), .imem_instr(imem_instr_s),
    .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_pc(out_pc_s),
    .out_instr(out_instr_s), .fetch_halted(fetch_halted_s), .stall_cycles(stall_cycles_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_valid_s = 1'b0;
    out_ready = 1'b0;      out_ready_s = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h500; out_ready = 1'b1;
    redirect_valid_s = 1'b0; redirect_pc_s = '0; out_ready_s = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 64'h0) $display("FAIL rst_pc got %h want 0", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", out_instr); else n_pass++;
    n_checks++; if (fetch_halted !== 1'b0) $display("FAIL rst_halted got %b want 0", fetch_halted); else n_pass++;
    n_checks++; if (stall_cycles !== 32'h0) $display("FAIL rst_stall got %0d want 0", stall_cycles); else n_pass++;
    n_checks++; if (imem_addr !== 64'h0) $display("FAIL rst_addr got %h want 0", imem_addr); else n_pass++;
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    do_reset();
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_first_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 64'h0) $display("FAIL stream_first_pc got %h want 0", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 32'h0050_0093) $display("FAIL stream_first_instr got %h want 00500093", out_instr); else n_pass++;
    tick();
    n_checks++; if (out_pc !== 64'h4) $display("FAIL stream_second_pc got %h want 4", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 32'h0010_0113) $display("FAIL stream_second_instr got %h want 00100113", out_instr); else n_pass++;
    for (int i = 2; i < 6; i++) begin
      tick();
      exp_pc = 64'(i * 4);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== mem_word(exp_pc))
        $display("FAIL stream_seq%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, out_valid, out_pc, out_instr, exp_pc, mem_word(exp_pc));
      else n_pass++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (imem_addr !== 64'h8) $display("FAIL stall_addr got %h want 8", imem_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h0050_0093)
      $display("FAIL stall_head got v=%b pc=%h instr=%h want v=1 pc=0 instr=00500093", out_valid, out_pc, out_instr);
      else n_pass++;
    n_checks++; if (stall_cycles !== (PERF ? 32'd3 : 32'd0))
      $display("FAIL stall_count got %0d want %0d", stall_cycles, PERF ? 3 : 0); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_pc !== 64'h4 || out_valid !== 1'b1) $display("FAIL stall_drain1 got pc=%h v=%b want pc=4 v=1", out_pc, out_valid); else n_pass++;
    tick();
    n_checks++; if (out_pc !== 64'h8 || out_valid !== 1'b1) $display("FAIL stall_drain2 got pc=%h v=%b want pc=8 v=1", out_pc, out_valid); else n_pass++;
    n_checks++; if (stall_cycles !== (PERF ? 32'd3 : 32'd0))
      $display("FAIL stall_count_after got %0d want %0d", stall_cycles, PERF ? 3 : 0); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h43;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (imem_addr !== 64'h40) $display("FAIL redir_addr got %h want 40", imem_addr); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== mem_word(64'h40))
      $display("FAIL redir_first got v=%b pc=%h instr=%h want v=1 pc=40 instr=%h", out_valid, out_pc, out_instr, mem_word(64'h40));
      else n_pass++;
    n_checks++; if (stall_cycles !== (PERF ? 32'd1 : 32'd0))
      $display("FAIL redir_stall got %0d want %0d", stall_cycles, PERF ? 1 : 0); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_pc !== 64'h44) $display("FAIL redir_second got pc=%h want 44", out_pc); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_halt();
    logic [63:0] exp_pc;
    do_reset();
    out_ready_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 64'(i * 4);
      n_checks++;
      if (out_valid_s !== 1'b1 || out_pc_s !== exp_pc || fetch_halted_s !== (i == 3))
        $display("FAIL halt_seq%0d got v=%b pc=%h h=%b want v=1 pc=%h h=%b",
                 i, out_valid_s, out_pc_s, fetch_halted_s, exp_pc, (i == 3));
      else n_pass++;
    end
    n_checks++; if (imem_addr_s !== 64'h10) $display("FAIL halt_addr got %h want 10", imem_addr_s); else n_pass++;
    tick();
    n_checks++; if (out_valid_s !== 1'b0 || fetch_halted_s !== 1'b1)
      $display("FAIL halt_drained got v=%b h=%b want v=0 h=1", out_valid_s, fetch_halted_s); else n_pass++;
    tick();
    n_checks++; if (imem_addr_s !== 64'h10 || out_valid_s !== 1'b0)
      $display("FAIL halt_hold got addr=%h v=%b want addr=10 v=0", imem_addr_s, out_valid_s); else n_pass++;
    redirect_valid_s = 1'b1; redirect_pc_s = 64'h4;
    tick();
    redirect_valid_s = 1'b0;
    n_checks++; if (fetch_halted_s !== 1'b0 || imem_addr_s !== 64'h4)
      $display("FAIL halt_redir got h=%b addr=%h want h=0 addr=4", fetch_halted_s, imem_addr_s); else n_pass++;
    tick();
    n_checks++; if (out_valid_s !== 1'b1 || out_pc_s !== 64'h4 || out_instr_s !== 32'h0010_0113)
      $display("FAIL halt_resume got v=%b pc=%h instr=%h want v=1 pc=4 instr=00100113", out_valid_s, out_pc_s, out_instr_s);
      else n_pass++;
    out_ready_s = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h200)
      $display("FAIL mid_setup got v=%b pc=%h want v=1 pc=200", out_valid, out_pc); else n_pass++;
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h300;
    tick();
    reset = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (imem_addr !== 64'h0 || out_valid !== 1'b0 || stall_cycles !== 32'h0)
      $display("FAIL mid_reset got addr=%h v=%b stall=%0d want addr=0 v=0 stall=0", imem_addr, out_valid, stall_cycles);
      else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h0)
      $display("FAIL mid_after got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); else n_pass++;
  endtask

  task automatic test_redirect_pop();
    do_reset();
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (out_pc !== 64'h4 || out_valid !== 1'b1) $display("FAIL rp_setup got pc=%h v=%b want pc=4 v=1", out_pc, out_valid); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 64'h80;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || imem_addr !== 64'h80)
      $display("FAIL rp_flush got v=%b addr=%h want v=0 addr=80", out_valid, imem_addr); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h80) $display("FAIL rp_first got v=%b pc=%h want v=1 pc=80", out_valid, out_pc); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'h84) $display("FAIL rp_second got v=%b pc=%h want v=1 pc=84", out_valid, out_pc); else n_pass++;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    redirect_valid_s = 1'b0; redirect_pc_s = '0; out_ready_s = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_halt();
    test_reset_mid();
    test_redirect_pop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end fetch stage sitting directly upstream of instruction_memory.
- Owns the program counter and drives the combinational memory address each cycle.
- Captures the returned 32-bit instruction with its PC into a small fetch buffer, which presents a valid/ready stream to decode.
- Handles redirects (branch/jump) by flushing the buffer, and stops fetching at the end of instruction memory.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- DEPTH, 2, fetch buffer entries; power of two, ≥2.
- IMEM_SIZE, 4095, instruction memory size in bytes; fetch allowed only while pc+3 < IMEM_SIZE.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  64  byte address to instruction memory; always equals the current pc.
- imem_instr  in  32  instruction returned combinationally for imem_addr, same cycle.
- redirect_valid  in  1  load a new PC and flush the buffer.
- redirect_pc  in  64  redirect target.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  64  PC of the head entry.
- out_instr  out  32  instruction of the head entry.
- fetch_halted  out  1  pc has passed the end of memory; no further fetches.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (reset=1 at a clock edge): pc=RESET_PC, buffer empty, count=0.
  - Outputs after reset: out_valid=0, out_pc=0, out_instr=0, fetch_halted=0, stall_cycles=0.
  - Reset overrides every other input, including a redirect in the same cycle.
- imem_addr = pc combinationally; pc[1:0] is always 0.
- fetch_ok = !fetch_halted && (pc + 3 < IMEM_SIZE).
  - The comparison is unsigned 64-bit; pc+3 overflow counts as out of range.
- fetch_halted = !(pc + 3 < IMEM_SIZE), registered view of pc.
  - Cleared only by reset or by a redirect to an in-range target.
- pop = out_valid && out_ready.
- push = fetch_ok && !redirect_valid && (count < DEPTH || pop).
  - A full buffer with a simultaneous pop still pushes, giving sustained throughput of 1 instr/cycle.
- On push:
  - entry {pc, imem_instr} is written at the tail;
  - pc <= pc + 4 (64-bit wrap).
- On pop: head advances. Latency from fetch to out_valid is 1 cycle; buffer is first-in first-out.
- count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged when both or neither occur.
- Redirect (redirect_valid=1, reset=0):
  - buffer flushed (count=0, head=tail=0);
  - pc <= {redirect_pc[63:2], 2'b00} (misaligned low bits dropped);
  - no push that cycle.
  - A pop in the same cycle is not counted: the entry is discarded, and decode must ignore its handshake on redirect cycles.
  - out_valid=0 in the following cycle; the first instruction at the new target is valid 2 cycles after redirect.
- Output contents:
  - out_pc and out_instr reflect the head entry whenever out_valid=1.
  - When empty they hold the last head contents (not required to be 0 except after reset).
- Stall hold: with out_ready=0, out_valid/out_pc/out_instr remain stable until accepted or redirected.
- Full buffer, no pop: pc and imem_addr hold; nothing is written.
- Halted: no pushes; out_valid drains remaining entries normally.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: stall_cycles increments by 1 (saturating at 32'hFFFF_FFFF) each cycle where fetch_ok=1, redirect_valid=0, and push=0 (buffer back-pressure). It is cleared by reset and not affected by redirect.
- Not defined: stall_cycles is constant 0 and no counter register is generated.

Test Plan:
- Reset, then out_ready=1 constantly with memory words 0x00500093, 0x00100113, … → out_valid first high in cycle 2 with out_pc=0, out_instr=0x00500093; next cycle out_pc=4; one instruction per cycle thereafter.
- Hold out_ready=0 from reset → exactly DEPTH=2 pushes (pc stops at 8, imem_addr=8), and the head stays at pc=0. Then assert out_ready=1 → entries pc 0, 4, 8 delivered in order with no gaps or duplicates. With FETCH_PERF_CNT_EN, stall_cycles counts the held cycles.
- Full buffer plus redirect_valid=1, redirect_pc=0x43 → out_valid=0 next cycle, imem_addr=0x40, first new entry has out_pc=0x40; old entries are never presented.
- IMEM_SIZE=16 with out_ready=1 → fetches pc 0, 4, 8, 12; then fetch_halted=1 with pc=16, out_valid drops after the last entry drains. A redirect to 0x4 clears fetch_halted and resumes fetching.
- Assert reset mid-stream with buffer half full and redirect_valid=1 in the same cycle → pc=RESET_PC, out_valid=0, stall_cycles=0; the redirect is ignored.
- Redirect asserted in the same cycle as a pop of the head → the head is not re-presented, and count=0 after the edge.
